// File: rtl/led_display_bcm_feeder.sv
// led_display_bcm_feeder: two-bank frame memory and BCM line sequencer feeding
// pixel pairs (upper row + row+ROWS/2) one plane bit at a time to an LED phy.
// Ports: clk_in/reset_in (sync, active-high), enable_in (run sequencing),
//   wr_en_in/wr_addr_in/wr_data_in (frame writes, {R,G,B}),
//   pix_valid_out/pix_ready_in/pix_top_out/pix_bot_out/pix_last_out (beat stream),
//   row_addr_out/oe_cycles_out (current line info), line_done_in (phy line done),
//   frame_start_out (pulse at first fetch of row 0 plane 0).
module led_display_bcm_feeder #(
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int COLOUR_BITS    = 4,
    parameter int OE_BASE        = 8,
    localparam int AW = $clog2(NUM_ROW_PIXELS * NUM_COL_PIXELS),
    localparam int RW = $clog2(NUM_ROW_PIXELS / 2),
    localparam int DW = 3 * COLOUR_BITS
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          enable_in,
    input  logic          wr_en_in,
    input  logic [AW-1:0] wr_addr_in,
    input  logic [DW-1:0] wr_data_in,
    output logic          pix_valid_out,
    input  logic          pix_ready_in,
    output logic [2:0]    pix_top_out,
    output logic [2:0]    pix_bot_out,
    output logic          pix_last_out,
    output logic [RW-1:0] row_addr_out,
    output logic [15:0]   oe_cycles_out,
    input  logic          line_done_in,
    output logic          frame_start_out
);

    localparam int CW    = $clog2(NUM_COL_PIXELS);
    localparam int PW    = (COLOUR_BITS > 1) ? $clog2(COLOUR_BITS) : 1;
    localparam int BW    = AW - 1;
    localparam int DEPTH = (NUM_ROW_PIXELS / 2) * NUM_COL_PIXELS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [DW-1:0] mem_top [DEPTH];
    logic [DW-1:0] mem_bot [DEPTH];

    logic [DW-1:0] rd_top_q, rd_bot_q;
    logic          last_q;
    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [CW-1:0] col_q, col_d;
    logic [BW-1:0] rd_addr;
    logic          col_end, plane_end, row_end;

    // Pick the bit of the current BCM plane out of each colour channel.
    function automatic logic [2:0] plane_bits(input logic [DW-1:0] w,
                                              input logic [PW-1:0] p);
        logic [COLOUR_BITS-1:0] r, g, b;
        {r, g, b} = w;
        return {r[p], g[p], b[p]};
    endfunction

    assign rd_addr   = {row_q, col_q};
    assign col_end   = (col_q == CW'(NUM_COL_PIXELS - 1));
    assign plane_end = (plane_q == PW'(COLOUR_BITS - 1));
    assign row_end   = (row_q == RW'(NUM_ROW_PIXELS / 2 - 1));

    // Frame memory is never reset; the address MSB picks the bottom bank.
    always_ff @(posedge clk_in) begin
        if (wr_en_in && !reset_in) begin
            if (wr_addr_in[AW-1]) begin
                mem_bot[wr_addr_in[BW-1:0]] <= wr_data_in;
            end else begin
                mem_top[wr_addr_in[BW-1:0]] <= wr_data_in;
            end
        end
    end

    // Read port: both banks in parallel, captured only in FETCH so the beat
    // holds steady through any downstream stall. Same-cycle writes read old.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rd_top_q <= '0;
            rd_bot_q <= '0;
            last_q   <= 1'b0;
        end else if (state_q == S_FETCH) begin
            rd_top_q <= mem_top[rd_addr];
            rd_bot_q <= mem_bot[rd_addr];
            last_q   <= col_end;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        plane_d = plane_q;
        col_d   = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable_in) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (pix_ready_in) begin
                    if (col_end) begin
                        state_d = S_WAIT;
                        col_d   = '0;
                    end else begin
                        state_d = S_FETCH;
                        col_d   = col_q + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                // enable_in is only looked at between lines.
                if (line_done_in) begin
                    state_d = enable_in ? S_FETCH : S_IDLE;
                    if (plane_end) begin
                        plane_d = '0;
                        row_d   = row_end ? '0 : row_q + RW'(1);
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            plane_q <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
        end
    end

    assign pix_valid_out   = (state_q == S_STREAM);
    assign pix_top_out     = plane_bits(rd_top_q, plane_q);
    assign pix_bot_out     = plane_bits(rd_bot_q, plane_q);
    assign pix_last_out    = last_q && pix_valid_out;
    assign row_addr_out    = row_q;
    assign oe_cycles_out   = 16'(OE_BASE) << plane_q;
    assign frame_start_out = (state_q == S_FETCH) && (col_q == '0) &&
                             (row_q == '0) && (plane_q == '0);

endmodule

// File: tb/tb_led_display_bcm_feeder.sv
// Testbench for led_display_bcm_feeder: frame-memory model plus line/plane
// sequence model, table vectors for first beats and randomized streaming.
module tb_led_display_bcm_feeder;

    localparam int ROWS = 32;
    localparam int COLS = 64;
    localparam int HALF = ROWS / 2;
    localparam int CB   = 4;
    localparam int OEB  = 8;

    logic        clk = 1'b0;
    logic        reset_in, enable_in, wr_en_in, pix_ready_in, line_done_in;
    logic [10:0] wr_addr_in;
    logic [11:0] wr_data_in;
    logic        pix_valid_out, pix_last_out, frame_start_out;
    logic [2:0]  pix_top_out, pix_bot_out;
    logic [3:0]  row_addr_out;
    logic [15:0] oe_cycles_out;

    always #5 clk = ~clk;

    led_display_bcm_feeder #(
        .NUM_ROW_PIXELS(ROWS),
        .NUM_COL_PIXELS(COLS),
        .COLOUR_BITS(CB),
        .OE_BASE(OEB)
    ) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .enable_in(enable_in),
        .wr_en_in(wr_en_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .pix_valid_out(pix_valid_out),
        .pix_ready_in(pix_ready_in),
        .pix_top_out(pix_top_out),
        .pix_bot_out(pix_bot_out),
        .pix_last_out(pix_last_out),
        .row_addr_out(row_addr_out),
        .oe_cycles_out(oe_cycles_out),
        .line_done_in(line_done_in),
        .frame_start_out(frame_start_out)
    );

    typedef struct {
        logic [2:0]  top;
        logic [2:0]  bot;
        logic [15:0] oe;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [11:0] mem_m [ROWS*COLS];
    int          m_row = 0;
    int          m_plane = 0;
    bit          rnd_wr = 1'b0;
    logic [2:0]  b0_top, b0_bot;
    logic [15:0] b0_oe;
    vec_t        tbl [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (row %0d plane %0d)",
                     name, act, exp, m_row, m_plane);
        end
    endtask

    function automatic logic [2:0] bits_of(input logic [11:0] w, input int p);
        logic [11:0] s;
        s = w >> p;
        return {s[8], s[4], s[0]};
    endfunction

    // One clock; optional random background write away from the row pair
    // being displayed; model memory follows committed writes.
    task automatic tick();
        int a;
        if (rnd_wr && !wr_en_in && ($urandom_range(0, 3) == 0)) begin
            a = $urandom_range(0, ROWS * COLS - 1);
            if (((a / COLS) % HALF) != m_row) begin
                wr_en_in   = 1'b1;
                wr_addr_in = 11'(a);
                wr_data_in = 12'($urandom);
            end
        end
        @(posedge clk);
        #1;
        if (wr_en_in && !reset_in) mem_m[wr_addr_in] = wr_data_in;
        wr_en_in = 1'b0;
    endtask

    // Streams one full line starting from its fetch cycle, then issues
    // line_done and checks the next line's start.
    task automatic run_line(input bit rnd, input int long_col,
                            input int haz_col, input int drop_col);
        int n;
        for (int c = 0; c < COLS; c++) begin
            int          ta = m_row * COLS + c;
            int          ba = (m_row + HALF) * COLS + c;
            logic [11:0] wt, wb;
            wt = mem_m[ta];
            wb = mem_m[ba];
            if (c == haz_col) begin
                wr_en_in   = 1'b1;
                wr_addr_in = 11'(ta);
                wr_data_in = ~mem_m[ta];
            end
            if (c == drop_col) enable_in = 1'b0;
            n = 0;
            while (!pix_valid_out && n < 8) begin
                tick();
                n++;
            end
            if (!pix_valid_out) begin
                chk("beat_timeout", pix_valid_out, 1);
                return;
            end
            chk("top", pix_top_out, bits_of(wt, m_plane));
            chk("bot", pix_bot_out, bits_of(wb, m_plane));
            chk("last", pix_last_out, c == COLS - 1);
            chk("row", row_addr_out, m_row);
            chk("oe", oe_cycles_out, OEB << m_plane);
            chk("fs_beat", frame_start_out, 0);
            if (c == 0) begin
                b0_top = pix_top_out;
                b0_bot = pix_bot_out;
                b0_oe  = oe_cycles_out;
            end
            n = (c == long_col) ? 10 : (rnd ? $urandom_range(0, 2) : 0);
            pix_ready_in = 1'b0;
            for (int s = 0; s < n; s++) begin
                line_done_in = rnd ? ($urandom_range(0, 4) == 0) : (s == 4);
                tick();
                line_done_in = 1'b0;
                chk("stall_valid", pix_valid_out, 1);
                chk("stall_top", pix_top_out, bits_of(wt, m_plane));
                chk("stall_bot", pix_bot_out, bits_of(wb, m_plane));
                chk("stall_last", pix_last_out, c == COLS - 1);
                chk("stall_row", row_addr_out, m_row);
                chk("stall_oe", oe_cycles_out, OEB << m_plane);
            end
            pix_ready_in = 1'b1;
            line_done_in = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            pix_ready_in = 1'b0;
            line_done_in = 1'b0;
        end
        chk("wait_valid", pix_valid_out, 0);
        n = rnd ? $urandom_range(0, 3) : 2;
        for (int s = 0; s < n; s++) begin
            tick();
            chk("wait_valid", pix_valid_out, 0);
        end
        line_done_in = 1'b1;
        tick();
        line_done_in = 1'b0;
        m_plane++;
        if (m_plane == CB) begin
            m_plane = 0;
            m_row   = (m_row + 1) % HALF;
        end
        chk("line_start_valid", pix_valid_out, 0);
        chk("fs_start", frame_start_out, enable_in && m_row == 0 && m_plane == 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0] = '{3'b100, 3'b000, 16'd8};
        tbl[1] = '{3'b100, 3'b001, 16'd16};
        tbl[2] = '{3'b100, 3'b000, 16'd32};
        tbl[3] = '{3'b100, 3'b001, 16'd64};

        reset_in = 1'b1; enable_in = 1'b0; wr_en_in = 1'b0;
        wr_addr_in = '0; wr_data_in = '0;
        pix_ready_in = 1'b0; line_done_in = 1'b0;
        tick();
        tick();
        chk("rst_valid", pix_valid_out, 0);
        chk("rst_top", pix_top_out, 0);
        chk("rst_bot", pix_bot_out, 0);
        chk("rst_last", pix_last_out, 0);
        chk("rst_row", row_addr_out, 0);
        chk("rst_oe", oe_cycles_out, OEB);
        chk("rst_fs", frame_start_out, 0);
        reset_in = 1'b0;

        for (int i = 0; i < ROWS * COLS; i++) begin
            wr_en_in   = 1'b1;
            wr_addr_in = 11'(i);
            wr_data_in = (i == 0) ? 12'hF00 :
                         (i == 1024) ? 12'h00A : 12'($urandom);
            tick();
        end

        // Write while in reset must not land.
        reset_in   = 1'b1;
        wr_en_in   = 1'b1;
        wr_addr_in = 11'd0;
        wr_data_in = 12'h0FF;
        tick();
        reset_in = 1'b0;
        tick();

        enable_in = 1'b1;
        tick();
        chk("first_fs", frame_start_out, 1);
        chk("first_valid", pix_valid_out, 0);

        for (int i = 0; i < 4; i++) begin
            run_line(1'b0, (i == 0) ? 5 : -1, (i == 0) ? 3 : -1, -1);
            chk("tbl_top", b0_top, tbl[i].top);
            chk("tbl_bot", b0_bot, tbl[i].bot);
            chk("tbl_oe", b0_oe, tbl[i].oe);
        end

        rnd_wr = 1'b1;
        for (int i = 0; i < 60; i++) run_line(1'b1, -1, -1, -1);

        run_line(1'b1, -1, -1, 10);
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("idle_valid", pix_valid_out, 0);
            chk("idle_fs", frame_start_out, 0);
        end
        chk("idle_row", row_addr_out, 0);
        chk("idle_oe", oe_cycles_out, 16);
        enable_in = 1'b1;
        tick();
        chk("resume_fs", frame_start_out, 0);
        for (int i = 0; i < 4; i++) run_line(1'b1, -1, -1, -1);

        n = 0;
        while (!pix_valid_out && n < 8) begin
            tick();
            n++;
        end
        chk("pre_rst_valid", pix_valid_out, 1);
        chk("pre_rst_row", row_addr_out, m_row);
        pix_ready_in = 1'b0;
        tick();
        chk("pre_rst_hold", pix_valid_out, 1);
        reset_in = 1'b1;
        tick();
        chk("mid_rst_valid", pix_valid_out, 0);
        chk("mid_rst_row", row_addr_out, 0);
        chk("mid_rst_oe", oe_cycles_out, OEB);
        chk("mid_rst_top", pix_top_out, 0);
        chk("mid_rst_last", pix_last_out, 0);
        chk("mid_rst_fs", frame_start_out, 0);
        reset_in = 1'b0;
        m_row    = 0;
        m_plane  = 0;
        tick();
        chk("restart_fs", frame_start_out, 1);
        run_line(1'b1, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
